// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot select arbiter.
//   state_t / S_*  : arbiter FSM state encoding
//   idx_w()        : width of a binary lane index for n lanes (min 1)
//   onehot_to_idx(): binary position of the lowest set bit of a one-hot vector
package onehot_pkg;

    localparam int unsigned MAX_LANES = 32;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_GRANT = 2'd1;
    localparam state_t S_GAP   = 2'd2;

    // Index width for n lanes; never zero so single-bit indices stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned onehot_to_idx(input logic [MAX_LANES-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_select_arbiter_if.sv
// Request/grant bundle between request sources and the one-hot select arbiter.
//   req       : per-lane level request
//   rel       : owner finished, ends the current grant ("release" is a reserved word)
//   sel       : one-hot (or zero) select for the downstream mux
//   gnt_idx   : binary index of the granted lane, valid with gnt_valid
//   gnt_valid : sel is non-zero
//   timeout   : one-cycle pulse on forced release
interface onehot_select_arbiter_if #(
    parameter int unsigned N = 4
);
    import onehot_pkg::*;

    localparam int unsigned IDX_W = idx_w(N);

    logic [N-1:0]     req;
    logic             rel;
    logic [N-1:0]     sel;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    // Request side
    modport master (
        output req,
        output rel,
        input  sel,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  rel,
        output sel,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/onehot_select_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request scanning last_ptr+1,
// last_ptr+2, ... modulo N.
//   req      : request vector
//   last_ptr : most recently granted lane
//   pick_c   : chosen lane (meaningful only when any_c=1)
//   any_c    : at least one request present
module onehot_select_arbiter_rr_pick
    import onehot_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [idx_w(N)-1:0] last_ptr,
    output logic [idx_w(N)-1:0] pick_c,
    output logic                any_c
);

    localparam int unsigned IDX_W = idx_w(N);

    logic [N-1:0] rot_c;
    logic [N-1:0] rot_low_c;
    int unsigned  start_c;
    int unsigned  off_c;

    // Rotate so the lane after last_ptr sits at bit 0.
    always_comb begin
        rot_c   = '0;
        start_c = (32'(last_ptr) + 32'd1) % N;
        for (int i = 0; i < int'(N); i++) begin
            rot_c[i] = req[IDX_W'((start_c + 32'(i)) % N)];
        end
    end

    // Priority-encode the rotated vector, then un-rotate back to a lane number.
    always_comb begin
        rot_low_c = rot_c & (~rot_c + N'(1));
        off_c     = onehot_to_idx(MAX_LANES'(rot_low_c));
        pick_c    = IDX_W'((start_c + off_c) % N);
        any_c     = |req;
    end

endmodule

// File: rtl/onehot_select_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for a downstream
// one-hot mux. A grant lasts until rel, until the owner drops its request, or
// until MAX_HOLD cycles elapse; a one-cycle all-zero gap always separates
// grants so the mux never sees two bits set.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of onehot_select_arbiter_if (req/rel in, sel/gnt_idx/
//                gnt_valid/timeout out, all outputs registered)
module onehot_select_arbiter
    import onehot_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    onehot_select_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = idx_w(N);
    localparam int unsigned HC_W  = $clog2(MAX_HOLD + 1);

    state_t           state_q,     state_d;
    logic [N-1:0]     sel_q,       sel_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;
    logic [HC_W-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [IDX_W-1:0] last_ptr_q,  last_ptr_d;

    logic [IDX_W-1:0] pick_c;
    logic             any_c;
    logic             owner_req_c;
    logic             hold_max_c;
    logic             end_c;

    onehot_select_arbiter_rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .pick_c   (pick_c),
        .any_c    (any_c)
    );

    // Grant end conditions for the current owner.
    always_comb begin
        owner_req_c = bus.req[gnt_idx_q];
        hold_max_c  = (hold_cnt_q == HC_W'(MAX_HOLD));
        end_c       = bus.rel || !owner_req_c || hold_max_c;
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_ptr_d  = last_ptr_q;

        case (state_q)
            S_IDLE: begin
                sel_d       = '0;
                gnt_valid_d = 1'b0;
                if (any_c) begin
                    state_d     = S_GRANT;
                    sel_d       = N'(1) << pick_c;
                    gnt_idx_d   = pick_c;
                    gnt_valid_d = 1'b1;
                    last_ptr_d  = pick_c;
                    hold_cnt_d  = HC_W'(1);
                end
            end
            S_GRANT: begin
                if (end_c) begin
                    state_d     = S_GAP;
                    sel_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    // Only a pure expiry counts as a timeout; release/drop wins.
                    timeout_d   = hold_max_c && !bus.rel && owner_req_c;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HC_W'(1);
                end
            end
            S_GAP: begin
                state_d     = S_IDLE;
                sel_d       = '0;
                gnt_valid_d = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                sel_d       = '0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_ptr_q  <= IDX_W'(N - 1);
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_onehot_select_arbiter.sv
// Self-checking bench for onehot_select_arbiter: directed scenarios followed
// by a randomized run, all checked against a cycle-level behavioural model.
module tb_onehot_select_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    onehot_select_arbiter_if #(.N(N)) bus();

    onehot_select_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: owner lane (-1 none), cycles held, last winner, gap flag.
    int m_owner;
    int m_hold;
    int m_last;
    bit m_gap;
    bit m_timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_hold    = 0;
        m_last    = N - 1;
        m_gap     = 1'b0;
        m_timeout = 1'b0;
    endtask

    function automatic bit lane_req(input int lane);
        return ((bus.req >> lane) & 4'b0001) != 4'b0000;
    endfunction

    // One clock of the arbiter's rules, using inputs present at the edge.
    task automatic model_step();
        m_timeout = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner >= 0) begin
            if (bus.rel || !lane_req(m_owner) || m_hold == MAX_HOLD) begin
                m_timeout = (m_hold == MAX_HOLD) && !bus.rel && lane_req(m_owner);
                m_owner   = -1;
                m_gap     = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            for (int k = 1; k <= int'(N); k++) begin
                if (m_owner < 0 && lane_req((m_last + k) % N)) begin
                    m_owner = (m_last + k) % N;
                    m_last  = m_owner;
                    m_hold  = 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [31:0] exp_sel;
        exp_sel = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check("sel",       32'(bus.sel),         exp_sel);
        check("gnt_valid", 32'(bus.gnt_valid),   32'(m_owner >= 0));
        check("timeout",   32'(bus.timeout),     32'(m_timeout));
        check("onehot0",   32'($onehot0(bus.sel)), 32'd1);
        if (m_owner >= 0) begin
            check("gnt_idx", 32'(bus.gnt_idx), 32'(m_owner));
        end
    endtask

    // Advance one clock, update model, sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_model();
    endtask

    // Assert reset (possibly mid-cycle), check async clear, release aligned.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_sel",       32'(bus.sel),       32'd0);
        check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_gnt_idx",   32'(bus.gnt_idx),   32'd0);
        check("rst_timeout",   32'(bus.timeout),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int grants[$];
        int exp_order[5];
        int gcnt;
        int n_on;
        int pulses;
        bit seen_zero;

        bus.req = '0;
        bus.rel = 1'b0;
        model_reset();
        #1;
        do_reset();

        // 1: basic grant, release, gap, idle, next lane
        bus.req = 4'b0101;
        tick();
        check("t1_sel_first", 32'(bus.sel), 32'h1);
        bus.rel = 1'b1;
        tick();
        check("t1_sel_gap", 32'(bus.sel), 32'h0);
        bus.rel = 1'b0;
        tick();
        check("t1_sel_idle", 32'(bus.sel), 32'h0);
        tick();
        check("t1_sel_next", 32'(bus.sel), 32'h4);

        // 2: all lanes requesting, release every 2nd granted cycle
        bus.req = '0;
        do_reset();
        bus.req = 4'b1111;
        gcnt = 0;
        for (int c = 0; c < 60 && grants.size() < 5; c++) begin
            tick();
            bus.rel = 1'b0;
            if (bus.gnt_valid) begin
                gcnt++;
                if (gcnt == 2) begin
                    grants.push_back(int'(bus.gnt_idx));
                    bus.rel = 1'b1;
                    gcnt    = 0;
                end
            end
        end
        bus.rel = 1'b0;
        exp_order = '{0, 1, 2, 3, 0};
        check("t2_grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check("t2_grant_order", 32'(grants[i]), 32'(exp_order[i]));
        end

        // 3: single requester held past MAX_HOLD
        bus.req = '0;
        do_reset();
        bus.req = 4'b0010;
        tick();
        n_on      = (bus.sel == 4'b0010) ? 1 : 0;
        pulses    = 0;
        seen_zero = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.sel == 4'b0010 && !seen_zero) n_on++;
            else seen_zero = 1'b1;
            if (bus.timeout) pulses++;
        end
        check("t3_hold_cycles", 32'(n_on),   32'(MAX_HOLD));
        check("t3_timeouts",    32'(pulses), 32'd1);

        // 4: release and request drop together on lane 2
        bus.req = '0;
        do_reset();
        bus.req = 4'b0100;
        tick();
        check("t4_sel_lane2", 32'(bus.sel), 32'h4);
        tick();
        bus.req = '0;
        bus.rel = 1'b1;
        tick();
        check("t4_sel_gap",     32'(bus.sel),     32'h0);
        check("t4_no_timeout",  32'(bus.timeout), 32'd0);
        bus.rel = 1'b0;
        tick();
        check("t4_no_timeout2", 32'(bus.timeout), 32'd0);

        // 5: reset mid-grant on lane 3, then lane 0 wins first
        bus.req = 4'b1000;
        tick();
        tick();
        check("t5_sel_lane3", 32'(bus.sel), 32'h8);
        #2;
        do_reset();
        bus.req = 4'b1001;
        tick();
        check("t5_sel_lane0", 32'(bus.sel), 32'h1);

        // 6: no requests for 20 cycles, then randomized traffic
        bus.req = '0;
        tick();
        tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            check("t6_idle_valid", 32'(bus.gnt_valid), 32'd0);
        end
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(5, 0) == 0) bus.req = N'($urandom);
            bus.rel = ($urandom_range(7, 0) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
